// File: rtl/led_sequencer.sv
// Lock-gated LED pattern sequencer.
// It waits for a synchronized PLL lock and requires lock to stay stable for LOCK_WAIT cycles.
// It then steps one of four LED patterns every MODULE cycles.
// A pending mode is applied only at a step boundary or on entry into RUN.
module led_sequencer #(
    parameter int unsigned MODULE    = 50000000,
    parameter int unsigned LOCK_WAIT = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       locked,
    input  logic [1:0] mode_in,
    input  logic       mode_load,
    output logic [7:0] leds,
    output logic       step,
    output logic       running,
    output logic [1:0] mode
);

    localparam int unsigned DivW = (MODULE > 1) ? $clog2(MODULE) : 1;
    localparam int unsigned SetW = $clog2(LOCK_WAIT + 1);

    localparam logic [DivW-1:0] DivLast = DivW'(MODULE - 1);
    localparam logic [DivW-1:0] DivOne  = DivW'(1);
    localparam logic [SetW-1:0] SetLast = SetW'(LOCK_WAIT - 1);
    localparam logic [SetW-1:0] SetOne  = SetW'(1);

    localparam logic [1:0] ModeWalk   = 2'd0;
    localparam logic [1:0] ModeBounce = 2'd1;
    localparam logic [1:0] ModeBinary = 2'd2;
    localparam logic [1:0] ModeBlink  = 2'd3;

    typedef enum logic [1:0] {
        StWaitLock,
        StSettle,
        StRun
    } state_e;

    state_e          state_q, state_d;
    logic            lk1_q, lk2_q;
    logic [DivW-1:0] div_q, div_d;
    logic [SetW-1:0] set_q, set_d;
    logic [7:0]      leds_q, leds_d;
    logic            step_q, step_d;
    logic [1:0]      mode_q, mode_d;
    logic            pend_q, pend_d;
    logic [1:0]      pend_mode_q, pend_mode_d;
    logic            dir_up_q, dir_up_d;

    logic            apply_pend;
    logic [1:0]      next_mode;

    function automatic logic [7:0] init_pattern(input logic [1:0] m);
        return ((m == ModeWalk) || (m == ModeBounce)) ? 8'h01 : 8'h00;
    endfunction

    // State register, lock synchronizer and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StWaitLock;
            lk1_q       <= 1'b0;
            lk2_q       <= 1'b0;
            div_q       <= '0;
            set_q       <= '0;
            leds_q      <= 8'h00;
            step_q      <= 1'b0;
            mode_q      <= ModeWalk;
            pend_q      <= 1'b0;
            pend_mode_q <= 2'd0;
            dir_up_q    <= 1'b1;
        end else begin
            state_q     <= state_d;
            lk1_q       <= locked;
            lk2_q       <= lk1_q;
            div_q       <= div_d;
            set_q       <= set_d;
            leds_q      <= leds_d;
            step_q      <= step_d;
            mode_q      <= mode_d;
            pend_q      <= pend_d;
            pend_mode_q <= pend_mode_d;
            dir_up_q    <= dir_up_d;
        end
    end

    // Next-state logic: lock qualification, step divider, pattern advance and pending mode.
    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        set_d       = set_q;
        leds_d      = leds_q;
        step_d      = 1'b0;
        mode_d      = mode_q;
        pend_d      = pend_q;
        pend_mode_d = pend_mode_q;
        dir_up_d    = dir_up_q;
        apply_pend  = 1'b0;
        next_mode   = pend_q ? pend_mode_q : mode_q;

        unique case (state_q)
            StWaitLock: begin
                leds_d = 8'h00;
                div_d  = '0;
                set_d  = '0;
                if (lk2_q) begin
                    state_d = StSettle;
                end
            end
            StSettle: begin
                leds_d = 8'h00;
                div_d  = '0;
                if (!lk2_q) begin
                    state_d = StWaitLock;
                    set_d   = '0;
                end else if (set_q == SetLast) begin
                    state_d    = StRun;
                    apply_pend = pend_q;
                    mode_d     = next_mode;
                    leds_d     = init_pattern(next_mode);
                    dir_up_d   = 1'b1;
                    set_d      = '0;
                end else begin
                    set_d = set_q + SetOne;
                end
            end
            StRun: begin
                if (!lk2_q) begin
                    // Lock lost: go dark immediately, but keep mode and pending.
                    state_d = StWaitLock;
                    leds_d  = 8'h00;
                    div_d   = '0;
                end else if (div_q == DivLast) begin
                    div_d  = '0;
                    step_d = 1'b1;
                    if (pend_q) begin
                        // A newly applied mode restarts at its initial pattern without advancing.
                        apply_pend = 1'b1;
                        mode_d     = pend_mode_q;
                        leds_d     = init_pattern(pend_mode_q);
                        dir_up_d   = 1'b1;
                    end else begin
                        case (mode_q)
                            ModeWalk:   leds_d = {leds_q[6:0], leds_q[7]};
                            ModeBounce: begin
                                if (dir_up_q) begin
                                    if (leds_q[7]) begin
                                        leds_d   = 8'h40;
                                        dir_up_d = 1'b0;
                                    end else begin
                                        leds_d = {leds_q[6:0], 1'b0};
                                    end
                                end else begin
                                    if (leds_q[0]) begin
                                        leds_d   = 8'h02;
                                        dir_up_d = 1'b1;
                                    end else begin
                                        leds_d = {1'b0, leds_q[7:1]};
                                    end
                                end
                            end
                            ModeBinary: leds_d = leds_q + 8'd1;
                            ModeBlink:  leds_d = ~leds_q;
                            default:    leds_d = leds_q;
                        endcase
                    end
                end else begin
                    div_d = div_q + DivOne;
                end
            end
            default: begin
                state_d = StWaitLock;
                leds_d  = 8'h00;
                div_d   = '0;
                set_d   = '0;
            end
        endcase

        // A load on this edge overrides clearing, so it survives to the next application point.
        if (mode_load) begin
            pend_d      = 1'b1;
            pend_mode_d = mode_in;
        end else if (apply_pend) begin
            pend_d = 1'b0;
        end
    end

    assign leds    = leds_q;
    assign step    = step_q;
    assign running = (state_q == StRun);
    assign mode    = mode_q;

endmodule
